// File: rtl/upsampler_h_window_fp16_pkg.sv
// -----------------------------------------------------------------------------
// upsampler_h_pkg
// Shared definitions for the horizontal zero-stuffing window generator:
//   - state_e   : sequencer states (pixel, stuffed zero, two end-of-row flushes)
//   - FP_ZERO   : the +0.0 FP16 word (all-zero bit pattern)
//   - UPS_TAPS  : number of taps in the horizontal window
// -----------------------------------------------------------------------------
package upsampler_h_pkg;

  typedef enum logic [1:0] {
    S_PIX    = 2'd0,
    S_ZERO   = 2'd1,
    S_FLUSH0 = 2'd2,
    S_FLUSH1 = 2'd3
  } state_e;

  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP_ZERO = '0;

  localparam int UPS_TAPS = 5;

endpackage

// File: rtl/upsampler_h_window_fp16_shift.sv
// -----------------------------------------------------------------------------
// fp_shift_window
// UPS_TAPS-deep shift register of FP words. Tap [UPS_TAPS-1] receives the
// newest word, tap [0] holds the oldest.
//
// Ports:
//   clk_i       in   clock
//   rst_i       in   synchronous active-high reset, clears all taps
//   shift_en_i  in   shift taps down by one and insert din_i at the top
//   load_i      in   load {din_i, 0, 0, ...}; has priority over shift_en_i
//   din_i       in   word to insert
//   taps_o      out  current tap contents
// -----------------------------------------------------------------------------
module fp_shift_window
  import upsampler_h_pkg::*;
#(
  parameter int FP_W = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               shift_en_i,
  input  logic                               load_i,
  input  logic [FP_W-1:0]                    din_i,
  output logic [UPS_TAPS-1:0][FP_W-1:0]      taps_o
);

  logic [UPS_TAPS-1:0][FP_W-1:0] taps_q;
  logic [UPS_TAPS-1:0][FP_W-1:0] taps_d;

  always_comb begin
    taps_d = taps_q;
    if (load_i) begin
      // A load wipes any history, which doubles as the left padding of a row.
      for (int i = 0; i < UPS_TAPS - 1; i++) begin
        taps_d[i] = FP_W'(FP_ZERO);
      end
      taps_d[UPS_TAPS-1] = din_i;
    end else if (shift_en_i) begin
      for (int i = 0; i < UPS_TAPS - 1; i++) begin
        taps_d[i] = taps_q[i+1];
      end
      taps_d[UPS_TAPS-1] = din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/upsampler_h_window_fp16.sv
// -----------------------------------------------------------------------------
// upsampler_h_window_fp16
// Horizontal zero-stuffing window generator for a 1x5 FP16 upsampling
// convolution. Every accepted pixel is followed by a +0.0 sample, so the row
// doubles in width; two flush samples after the last pixel provide the right
// padding. Each shift presents a 1x5 window centred on stuffed column c.
//
// Ports:
//   clk_i     in   clock
//   rst_i     in   synchronous active-high reset
//   data_i    in   input pixel (FP_WIDTH_REG bits)
//   col_i     in   input pixel column (checked only with the macro below)
//   row_i     in   input row, latched on pixel column 0
//   valid_i   in   input pixel valid
//   ready_o   out  pixel accepted this cycle when valid_i is also high
//   window_o  out  [0][0] = column c-2 ... [0][4] = column c+2
//   col_o     out  stuffed column c of the window centre
//   row_o     out  row of the window
//   valid_o   out  window valid
//   err_o     out  sticky column-sequence error (macro builds only)
//
// Optional feature macro: UPSAMPLER_H_WINDOW_COL_CHECK_EN
//   When defined, col_i is compared against the expected pixel column on every
//   handshake and err_o latches any mismatch until reset.
// -----------------------------------------------------------------------------
module upsampler_h_window_fp16
  import upsampler_h_pkg::*;
#(
  parameter int EXP_WIDTH     = 5,
  parameter int FRAC_WIDTH    = 10,
  parameter int WINDOW_WIDTH  = 5,
  parameter int WINDOW_HEIGHT = 1,
  parameter int IMAGE_WIDTH   = 320,
  parameter int FP_WIDTH_REG  = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_i,
  input  logic [FP_WIDTH_REG-1:0]                                data_i,
  input  logic [15:0]                                            col_i,
  input  logic [15:0]                                            row_i,
  input  logic                                                   valid_i,
  output logic                                                   ready_o,
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o,
  output logic [15:0]                                            col_o,
  output logic [15:0]                                            row_o,
  output logic                                                   valid_o
`ifdef UPSAMPLER_H_WINDOW_COL_CHECK_EN
  ,
  output logic                                                   err_o
`endif
);

  generate
    if (WINDOW_WIDTH != UPS_TAPS) begin : g_bad_window_width
      $error("upsampler_h_window_fp16: WINDOW_WIDTH must be 5");
    end
    if (WINDOW_HEIGHT != 1) begin : g_bad_window_height
      $error("upsampler_h_window_fp16: WINDOW_HEIGHT must be 1");
    end
    if (IMAGE_WIDTH < 2) begin : g_bad_image_width
      $error("upsampler_h_window_fp16: IMAGE_WIDTH must be at least 2");
    end
  endgenerate

  // Sample index k runs 0 .. 2*IMAGE_WIDTH+1 within a row.
  localparam int CNT_W = $clog2(2 * IMAGE_WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_ZERO_K = CNT_W'(2 * IMAGE_WIDTH - 1);
  localparam logic [CNT_W-1:0] FIRST_VALID_K = CNT_W'(2);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [15:0]                  col_q, col_d;
  logic [15:0]                  row_q, row_d;
  logic                         valid_q, valid_d;

  logic                         hs;
  logic                         first_pix;
  logic                         shift_en;
  logic                         load;
  logic [FP_WIDTH_REG-1:0]      shift_din;
  logic [CNT_W-1:0]             k_new;
  logic [UPS_TAPS-1:0][FP_WIDTH_REG-1:0] taps;

`ifdef UPSAMPLER_H_WINDOW_COL_CHECK_EN
  logic                         err_q, err_d;
  logic [15:0]                  exp_col;
`else
  logic                         unused_col;
  assign unused_col = ^col_i;
`endif

  assign ready_o = (state_q == S_PIX) && !rst_i;
  assign hs      = valid_i && (state_q == S_PIX);

  // Inside S_PIX the counter is 0 only before the first pixel of a row: after
  // any accepted pixel the following zero shift leaves it odd and non-zero.
  assign first_pix = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    shift_en  = 1'b0;
    load      = 1'b0;
    shift_din = FP_WIDTH_REG'(FP_ZERO);
    k_new     = cnt_q + CNT_W'(1);

    case (state_q)
      S_PIX: begin
        if (hs) begin
          state_d = S_ZERO;
          if (first_pix) begin
            load      = 1'b1;
            shift_din = data_i;
            k_new     = '0;
            row_d     = row_i;
          end else begin
            shift_en  = 1'b1;
            shift_din = data_i;
          end
          cnt_d = k_new;
        end
      end
      S_ZERO: begin
        shift_en = 1'b1;
        cnt_d    = k_new;
        state_d  = (k_new == LAST_ZERO_K) ? S_FLUSH0 : S_PIX;
      end
      S_FLUSH0: begin
        shift_en = 1'b1;
        cnt_d    = k_new;
        state_d  = S_FLUSH1;
      end
      S_FLUSH1: begin
        // Output column still uses k_new; the stored counter restarts the row.
        shift_en = 1'b1;
        cnt_d    = '0;
        state_d  = S_PIX;
      end
      default: begin
        state_d = S_PIX;
        cnt_d   = '0;
      end
    endcase

    // The window centre lags the newest sample by two taps.
    valid_d = (shift_en || load) && (k_new >= FIRST_VALID_K);
    col_d   = valid_d ? 16'(k_new - FIRST_VALID_K) : col_q;
  end

`ifdef UPSAMPLER_H_WINDOW_COL_CHECK_EN
  // Pixel j is shifted in as sample 2j, so its column is half the new index.
  assign exp_col = first_pix ? 16'd0 : 16'(k_new >> 1);

  always_comb begin
    err_d = err_q;
    if (hs && (col_i != exp_col)) begin
      err_d = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_PIX;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
`ifdef UPSAMPLER_H_WINDOW_COL_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
`ifdef UPSAMPLER_H_WINDOW_COL_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  fp_shift_window #(
    .FP_W (FP_WIDTH_REG)
  ) u_shift (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .shift_en_i (shift_en),
    .load_i     (load),
    .din_i      (shift_din),
    .taps_o     (taps)
  );

  assign window_o[0] = taps;
  assign col_o       = col_q;
  assign row_o       = row_q;
  assign valid_o     = valid_q;
`ifdef UPSAMPLER_H_WINDOW_COL_CHECK_EN
  assign err_o       = err_q;
`endif

endmodule

// File: tb/tb_upsampler_h_window_fp16.sv
// -----------------------------------------------------------------------------
// tb_upsampler_h_window_fp16
// Directed bench for the horizontal zero-stuffing window generator with a
// 4-pixel row. Expected windows come from the stuffed-row definition
// s[2k]=p[k], s[2k+1]=0, zero outside the row, plus hand-written constants.
// -----------------------------------------------------------------------------
module tb_upsampler_h_window_fp16;

  localparam int IW = 4;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [15:0]          data_i;
  logic [15:0]          col_i;
  logic [15:0]          row_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [0:0][4:0][15:0] window_o;
  logic [15:0]          col_o;
  logic [15:0]          row_o;
  logic                 valid_o;
`ifdef UPSAMPLER_H_WINDOW_COL_CHECK_EN
  logic                 err_o;
  logic                 err_exp;
`endif

  int nvec = 0;
  int nerr = 0;

  logic [15:0] pix  [IW];
  logic [15:0] colv [IW];
  bit          hand;

  upsampler_h_window_fp16 #(
    .IMAGE_WIDTH (IW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .col_i    (col_i),
    .row_i    (row_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .window_o (window_o),
    .col_o    (col_o),
    .row_o    (row_o),
    .valid_o  (valid_o)
`ifdef UPSAMPLER_H_WINDOW_COL_CHECK_EN
    ,
    .err_o    (err_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] s_at(input int n);
    if (n < 0 || n >= 2 * IW || (n % 2) != 0) return 16'h0000;
    return pix[n/2];
  endfunction

  function automatic logic [79:0] exp_win(input int c);
    logic [79:0] w;
    for (int t = 0; t < 5; t++) w[t*16 +: 16] = s_at(c - 2 + t);
    return w;
  endfunction

  // c < 0 means no window is expected this cycle.
  task automatic check_out(input int c, input logic [15:0] r);
    if (c < 0) begin
      chk("valid_low", 80'(valid_o), 80'd0);
    end else begin
      chk($sformatf("valid c=%0d", c), 80'(valid_o), 80'd1);
      chk($sformatf("col c=%0d", c), 80'(col_o), 80'(c));
      chk($sformatf("row c=%0d", c), 80'(row_o), 80'(r));
      chk($sformatf("win c=%0d", c), window_o, exp_win(c));
      if (hand) begin
        case (c)
          0: chk("hand c=0", window_o, {16'h4000, 16'h0000, 16'h3C00, 16'h0000, 16'h0000});
          1: chk("hand c=1", window_o, {16'h0000, 16'h4000, 16'h0000, 16'h3C00, 16'h0000});
          6: chk("hand c=6", window_o, {16'h0000, 16'h0000, 16'h4400, 16'h0000, 16'h4200});
          7: chk("hand c=7", window_o, {16'h0000, 16'h0000, 16'h0000, 16'h4400, 16'h0000});
          default: ;
        endcase
      end
    end
  endtask

  // Sends one row. gap_before: pixel index preceded by gap_len idle cycles.
  // npix < IW stops right after accepting pixel npix-1. hold_end keeps valid_i
  // high (with nxt0) through the last zero and the flush cycles.
  task automatic run_row(input logic [15:0] r, input int gap_before, input int gap_len,
                         input int npix, input bit hold_end, input logic [15:0] nxt0);
    int cycles = 0;
    for (int j = 0; j < npix; j++) begin
      if (j == gap_before) begin
        for (int g = 0; g < gap_len; g++) begin
          valid_i = 1'b0;
          chk("gap_ready", 80'(ready_o), 80'd1);
          step(); cycles++;
          chk("gap_valid", 80'(valid_o), 80'd0);
        end
      end
      chk($sformatf("ready pix%0d", j), 80'(ready_o), 80'd1);
      valid_i = 1'b1; data_i = pix[j]; col_i = colv[j]; row_i = r;
      step(); cycles++;
      valid_i = 1'b0;
      check_out((j == 0) ? -1 : 2 * j - 2, r);
`ifdef UPSAMPLER_H_WINDOW_COL_CHECK_EN
      if (colv[j] != 16'(j)) err_exp = 1'b1;
      chk($sformatf("err pix%0d", j), 80'(err_o), 80'(err_exp));
`endif
      if (j == npix - 1 && npix < IW) return;
      if (hold_end && j == IW - 1) begin
        valid_i = 1'b1; data_i = nxt0; col_i = 16'd0; row_i = r + 16'd1;
      end
      chk($sformatf("ready zero%0d", j), 80'(ready_o), 80'd0);
      step(); cycles++;
      check_out((j == 0) ? -1 : 2 * j - 1, r);
    end
    chk("ready flush0", 80'(ready_o), 80'd0);
    step(); cycles++;
    check_out(2 * IW - 2, r);
    chk("ready flush1", 80'(ready_o), 80'd0);
    step(); cycles++;
    check_out(2 * IW - 1, r);
    chk("row_cycles", 80'(cycles), 80'(2 * IW + 2 + ((gap_before < npix) ? gap_len : 0)));
    if (!hold_end) valid_i = 1'b0;
  endtask

  task automatic set_row(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    pix[0] = a; pix[1] = b; pix[2] = c; pix[3] = d;
    for (int i = 0; i < IW; i++) colv[i] = 16'(i);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; data_i = '0; col_i = '0; row_i = '0; hand = 1'b0;
`ifdef UPSAMPLER_H_WINDOW_COL_CHECK_EN
    err_exp = 1'b0;
`endif
    set_row(16'h3C00, 16'h4000, 16'h4200, 16'h4400);

    // Reset state
    step();
    chk("rst ready", 80'(ready_o), 80'd0);
    chk("rst valid", 80'(valid_o), 80'd0);
    chk("rst col", 80'(col_o), 80'd0);
    chk("rst row", 80'(row_o), 80'd0);
    chk("rst win", window_o, 80'd0);
`ifdef UPSAMPLER_H_WINDOW_COL_CHECK_EN
    chk("rst err", 80'(err_o), 80'd0);
`endif
    rst_i = 1'b0;
    #1;
    chk("ready after rst", 80'(ready_o), 80'd1);

    // Full-rate row 7 with hand-computed windows
    hand = 1'b1;
    run_row(16'd7, 99, 0, IW, 1'b0, 16'h0);
    hand = 1'b0;

    // Same row with a 3-cycle input gap before pixel 2
    run_row(16'd7, 2, 3, IW, 1'b0, 16'h0);

    // Back-to-back rows 0 and 1 with different pixels
    set_row(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    run_row(16'd0, 99, 0, IW, 1'b0, 16'h0);
    set_row(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
    run_row(16'd1, 99, 0, IW, 1'b0, 16'h0);

    // Mid-row reset after pixel 2 of row 3
    set_row(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    run_row(16'd3, 99, 0, 3, 1'b0, 16'h0);
    rst_i = 1'b1;
    #1;
    chk("midrst ready", 80'(ready_o), 80'd0);
    step();
    chk("midrst valid", 80'(valid_o), 80'd0);
    chk("midrst col", 80'(col_o), 80'd0);
    chk("midrst row", 80'(row_o), 80'd0);
    chk("midrst win", window_o, 80'd0);
    rst_i = 1'b0;
    #1;
    chk("midrst ready after", 80'(ready_o), 80'd1);
    set_row(16'h5A5A, 16'h6B6B, 16'h7C7C, 16'h8D8D);
    run_row(16'd4, 99, 0, IW, 1'b0, 16'h0);

    // valid_i held high across the row end: next pixel waits for the flush
    set_row(16'h1234, 16'h2345, 16'h3456, 16'h4567);
    run_row(16'd5, 99, 0, IW, 1'b1, 16'h7777);
    set_row(16'h7777, 16'h0001, 16'h8000, 16'hFFFF);
    run_row(16'd6, 99, 0, IW, 1'b0, 16'h0);

`ifdef UPSAMPLER_H_WINDOW_COL_CHECK_EN
    // Column sequence 0,1,3,.. : err rises on the third handshake and sticks
    set_row(16'h3C00, 16'h4000, 16'h4200, 16'h4400);
    colv[2] = 16'd3; colv[3] = 16'd3;
    run_row(16'd8, 99, 0, IW, 1'b0, 16'h0);
    chk("err sticky", 80'(err_o), 80'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    err_exp = 1'b0;
    chk("err cleared", 80'(err_o), 80'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
